stream_mux_rr: RTL and testbench

- Parametrised successor to the team's 6-to-1 case mux.
- Selects one of N_CH valid/ready input streams onto a single registered output stream.
- Two selection modes:
  - Fixed-select: external sel, with out-of-range select flagged.
  - Round-robin: bounded burst length per channel.
- Sits between multiple producer blocks and one shared consumer; 1-cycle registered latency.

---
 rtl/stream_mux_rr.sv | 142 ++++++++++++++
 tb/tb_stream_mux_rr.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: selects one of N_CH valid/ready input streams onto a single
// registered output stream. Fixed-select mode uses an external channel index;
// round-robin mode grants bursts of up to BURST_MAX beats per channel.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no owner; next grant comes from a search starting at ptr+1
//   S_BURST | channel ptr owns the output; cnt beats granted so far
module stream_mux_rr #(
  parameter int N_CH      = 6,
  parameter int WIDTH     = 4,
  parameter int BURST_MAX = 4,
  localparam int SEL_W    = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready,
  output logic                  err_sel
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t             r_state;
  state_t             w_nxt_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   w_nxt_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_nxt_cnt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [SEL_W-1:0]   r_out_ch;
  logic               r_err_sel;

  logic               w_load_en;
  logic               w_grant_vld;
  logic [SEL_W-1:0]   w_grant;
  logic               w_found;
  logic [SEL_W-1:0]   w_win;
  logic [SEL_W-1:0]   w_idx;

  // Wrap-around increment that stays correct for non-power-of-2 N_CH.
  function automatic logic [SEL_W-1:0] f_next(input logic [SEL_W-1:0] i);
    if (int'(i) + 1 == N_CH) return '0;
    else                     return SEL_W'(int'(i) + 1);
  endfunction

  assign w_load_en = !r_out_valid || out_ready;

  // Rotating search ptr+1, ptr+2, ... ending at ptr, so the owner comes last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = f_next(r_ptr);
    for (int i = 0; i < N_CH; i++) begin
      if (!w_found && in_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
      w_idx = f_next(w_idx);
    end
  end

  // Next-state and grant selection for both modes.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ptr   = r_ptr;
    w_nxt_cnt   = r_cnt;
    w_grant_vld = 1'b0;
    w_grant     = '0;
    if (!mode) begin
      w_nxt_state = S_IDLE;
      w_nxt_cnt   = '0;
      if (int'(sel) < N_CH && in_valid[sel]) begin
        w_grant_vld = 1'b1;
        w_grant     = sel;
      end
    end else if (r_state == S_BURST && in_valid[r_ptr] &&
                 int'(r_cnt) < BURST_MAX) begin
      w_grant_vld = 1'b1;
      w_grant     = r_ptr;
      w_nxt_cnt   = r_cnt + CNT_W'(1);
    end else if (w_found) begin
      w_grant_vld = 1'b1;
      w_grant     = w_win;
      w_nxt_ptr   = w_win;
      w_nxt_cnt   = CNT_W'(1);
      w_nxt_state = S_BURST;
    end else begin
      w_nxt_state = S_IDLE;
      w_nxt_cnt   = '0;
    end
  end

  // Ready goes only to the granted channel, and only when the output can load.
  always_comb begin
    in_ready = '0;
    if (w_load_en && w_grant_vld) in_ready[w_grant] = 1'b1;
  end

  // State register, output register and select-error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= SEL_W'(N_CH - 1);
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_err_sel   <= 1'b0;
    end else begin
      r_err_sel <= !mode && (int'(sel) >= N_CH);
      if (w_load_en) begin
        r_state <= w_nxt_state;
        r_ptr   <= w_nxt_ptr;
        r_cnt   <= w_nxt_cnt;
        if (w_grant_vld) begin
          r_out_valid <= 1'b1;
          r_out_data  <= in_data[w_grant*WIDTH +: WIDTH];
          r_out_ch    <= w_grant;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign err_sel   = r_err_sel;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr with default parameters (6 channels, 4-bit data,
// burst of 4). Expected output beats are queued as stimulus is applied and
// compared as the consumer accepts them.
module tb_stream_mux_rr;

  localparam int N_CH = 6;
  localparam int WIDTH = 4;
  localparam int SEL_W = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_ready;
  logic                  err_sel;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic [3:0] dat[N_CH];
  int rdy_cnt[N_CH];
  int grants;

  stream_mux_rr dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready), .err_sel(err_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input int ch);
    exp_q.push_back({4'(ch), dat[ch]});
  endtask

  task automatic drain(input int n);
    in_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Consumer side: a beat transfers on the edge following out_valid && out_ready.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {29'd0, out_ch}, 32'hFFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("beat_ch", 32'(out_ch), 32'(e[7:4]));
        chk("beat_data", 32'(out_data), 32'(e[3:0]));
      end
    end
  end

  initial begin
    dat = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h5, 4'h6};
    for (int k = 0; k < N_CH; k++) in_data[k*WIDTH +: WIDTH] = dat[k];
    reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    chk("rst_err_sel", 32'(err_sel), 0);
    reset = 1'b0;

    // Fixed select of channel 3, single beat.
    sel = 3'd3; in_valid = 6'b001000;
    #1;
    chk("fix_in_ready", 32'(in_ready), 32'h08);
    push_beat(3);
    step();
    chk("fix_out_valid", 32'(out_valid), 1);
    in_valid = '0;
    step();
    chk("fix_drop_valid", 32'(out_valid), 0);
    chk("fix_hold_ch", 32'(out_ch), 3);
    chk("fix_hold_data", 32'(out_data), 32'hA);

    // Out-of-range select.
    sel = 3'd6; in_valid = '1;
    #1;
    chk("oor6_in_ready", 32'(in_ready), 0);
    step();
    chk("oor6_out_valid", 32'(out_valid), 0);
    chk("oor6_err", 32'(err_sel), 1);
    sel = 3'd7;
    #1;
    chk("oor7_in_ready", 32'(in_ready), 0);
    step();
    chk("oor7_err", 32'(err_sel), 1);
    sel = 3'd2; in_valid = '0;
    step();
    chk("err_clear", 32'(err_sel), 0);

    // Round-robin, all channels valid: bursts of 4, channel 0 first.
    mode = 1'b1; in_valid = '1;
    for (int k = 0; k < N_CH; k++) rdy_cnt[k] = 0;
    grants = 0;
    for (int i = 0; i < 24; i++) push_beat(i / 4);
    push_beat(0);
    for (int i = 0; i < 25; i++) begin
      #1;
      if (i < 24) begin
        if (in_ready != '0) grants++;
        for (int k = 0; k < N_CH; k++) if (in_ready[k]) rdy_cnt[k]++;
      end
      step();
    end
    chk("rr_no_bubble", 32'(grants), 24);
    for (int k = 0; k < N_CH; k++) chk($sformatf("rr_ready_cnt%0d", k), 32'(rdy_cnt[k]), 4);
    drain(3);
    chk("rr_drained", 32'(out_valid), 0);

    // Channels 2 and 4; channel 2 drops after two beats, 4 re-granted without gap.
    grants = 0;
    foreach (dat[k]) if (0) grants = grants;
    push_beat(2); push_beat(2);
    for (int i = 0; i < 6; i++) push_beat(4);
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 2) ? 6'b010100 : 6'b010000;
      #1;
      if (in_ready != '0) grants++;
      step();
    end
    chk("rr24_no_idle", 32'(grants), 8);
    drain(3);

    // Back-pressure mid-burst: ptr is 4 and idle, so channel 5 owns next.
    for (int i = 0; i < 4; i++) push_beat(5);
    for (int i = 0; i < 4; i++) push_beat(0);
    in_valid = '1;
    step(); step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      step();
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_ch", 32'(out_ch), 5);
      chk("bp_out_data", 32'(out_data), 6);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    drain(3);

    // Reset mid-burst with owner channel 3 and a beat held in the output.
    push_beat(3); push_beat(3);
    in_valid = 6'b001000;
    step(); step();
    chk("pre_rst_valid", 32'(out_valid), 1);
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = '1;
    chk("post_rst_valid", 32'(out_valid), 0);
    chk("post_rst_err", 32'(err_sel), 0);
    #1;
    chk("post_rst_grant", 32'(in_ready), 32'h01);
    push_beat(0);
    step();
    drain(3);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
